// File: rtl/flash_word_fetch_if.sv
// flash_word_fetch_if: word-fetch request/response bus between requester and flash reader
interface flash_word_fetch_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  modport master (output req_valid, req_addr, input req_ready, rdata, rdata_valid);
  modport slave (input req_valid, req_addr, output req_ready, rdata, rdata_valid);
endinterface

// File: rtl/flash_word_fetch.sv
// flash_word_fetch: single-I/O SPI flash word reader with wake-up and continuous sequential reads
module flash_word_fetch #(
  parameter int CLK_DIV   = 1,
  parameter int CSB_HIGH  = 4,
  parameter int WAKE_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  flash_word_fetch_if.slave bus,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0,
  input  logic              flash_io1
);
  localparam int WGAP = CSB_HIGH > WAKE_WAIT ? CSB_HIGH : WAKE_WAIT;
  localparam int CW = $clog2((WGAP > 32 ? WGAP : 32) + 1);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {WAKE, WAKE_GAP, IDLE, CMD, ADDR, DATA, HOLD, CSGAP} state_t;
  state_t state, state_next;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, bits, gap;
  logic [31:0] sh_out, sh_in, rdata;
  logic [23:0] addr, next_addr, req_word;
  logic shifting, gapping, run, tick, rise, fall, last, gap_done, accept, hit, rdata_valid;
  assign shifting = state == WAKE || state == CMD || state == ADDR || state == DATA;
  assign gapping = state == WAKE_GAP || state == CSGAP;
  // the first cycle after reset keeps csb high, so SCK only runs once the frame is open
  assign run = shifting && !flash_csb;
  assign tick = div == DW'(CLK_DIV - 1);
  assign rise = run && tick && !flash_clk;
  assign fall = run && tick && flash_clk;
  assign bits = state == ADDR ? CW'(24) : state == DATA ? CW'(32) : CW'(8);
  assign last = fall && cnt == bits - CW'(1);
  assign gap = state == WAKE_GAP ? CW'(WGAP) : CW'(CSB_HIGH);
  assign gap_done = cnt + CW'(1) >= gap;
  assign req_word = {bus.req_addr[23:2], 2'b00};
  assign next_addr = addr + 24'd4;
  assign accept = bus.req_valid && bus.req_ready;
  assign hit = req_word == next_addr;
  assign bus.req_ready = state == IDLE || state == HOLD;
  assign bus.rdata = rdata;
  assign bus.rdata_valid = rdata_valid;
  assign flash_io0 = !flash_csb && sh_out[31];
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= WAKE;
    else state <= state_next;
  // next-state: each shift phase ends on the falling SCK edge of its last bit
  always_comb begin
    state_next = state;
    case (state)
      WAKE:     state_next = last ? WAKE_GAP : WAKE;
      WAKE_GAP: state_next = gap_done ? IDLE : WAKE_GAP;
      IDLE:     state_next = accept ? CMD : IDLE;
      CMD:      state_next = last ? ADDR : CMD;
      ADDR:     state_next = last ? DATA : ADDR;
      DATA:     state_next = last ? HOLD : DATA;
      HOLD:     state_next = accept ? (hit ? DATA : CSGAP) : HOLD;
      default:  state_next = gap_done ? CMD : CSGAP;
    endcase
  end
  // SPI engine: divider, SCK, bit/gap counter, shift registers and word output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      div <= '0;
      cnt <= '0;
      sh_out <= {8'hAB, 24'h0};
      sh_in <= '0;
      addr <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
    end else begin
      flash_csb <= !(state_next inside {WAKE, CMD, ADDR, DATA, HOLD});
      div <= run && !tick ? div + DW'(1) : '0;
      flash_clk <= run && (tick ? !flash_clk : flash_clk);
      cnt <= gapping ? (gap_done ? '0 : cnt + CW'(1)) : fall ? (last ? '0 : cnt + CW'(1)) : run ? cnt : '0;
      if ((accept && state == IDLE) || (state == CSGAP && gap_done)) sh_out <= {8'h03, 24'h0};
      else if (last && state == CMD) sh_out <= {addr, 8'h0};
      else if (fall) sh_out <= {sh_out[30:0], 1'b0};
      if (rise && state == DATA) sh_in <= {sh_in[30:0], flash_io1};
      if (accept) addr <= req_word;
      rdata_valid <= last && state == DATA;
      if (last && state == DATA) rdata <= {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};
    end
  end
endmodule

// File: tb/tb_flash_word_fetch.sv
// tb_flash_word_fetch: randomized self-checking bench with a behavioural SPI flash model
`timescale 1ns/1ps
module tb_flash_word_fetch;
  localparam int CSB_HIGH = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic flash_csb, flash_clk, flash_io0;
  logic flash_io1 = 1'b0;
  flash_word_fetch_if bus();
  flash_word_fetch #(.CLK_DIV(1), .CSB_HIGH(CSB_HIGH), .WAKE_WAIT(8)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1));
  always #10 clock = ~clock;
  int tests = 0, fails = 0;
  // flash contents: fixed bytes at 00..0F, random elsewhere, indexed by the low address byte
  logic [7:0] mem [256];
  logic [7:0] pre [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
  logic [7:0] cmd_q[$];
  logic [23:0] addr_q[$];
  logic [31:0] pq[$];
  int nb = 0, rbit = 0, hi_run = 0, last_hi = 0;
  logic [31:0] sr = '0;
  logic [7:0] fcmd = '0, rptr = '0, rbyte = '0;
  // flash model: collect command and address on rising SCK, drive data on falling SCK
  always @(negedge flash_csb) begin
    nb = 0;
    fcmd = 8'h00;
  end
  always @(posedge flash_clk) if (!flash_csb) begin
    sr = {sr[30:0], flash_io0};
    nb++;
    if (nb == 8) begin
      fcmd = sr[7:0];
      cmd_q.push_back(fcmd);
    end
    if (nb == 32 && fcmd == 8'h03) begin
      addr_q.push_back(sr[23:0]);
      rptr = sr[7:0];
      rbyte = mem[sr[7:0]];
      rbit = 0;
    end
  end
  always @(negedge flash_clk) if (!flash_csb && fcmd == 8'h03 && nb >= 32) begin
    flash_io1 = rbyte[7];
    rbyte = {rbyte[6:0], 1'b0};
    rbit++;
    if (rbit == 8) begin
      rptr = rptr + 8'd1;
      rbyte = mem[rptr];
      rbit = 0;
    end
  end
  // output monitor: word pulses and csb high run lengths
  always @(negedge clock) begin
    if (bus.rdata_valid) pq.push_back(bus.rdata);
    if (flash_csb) hi_run++;
    else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
    end
  end
  function automatic logic [31:0] word_at(input logic [23:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction
  task automatic do_read(input logic [23:0] a, input int budget, output logic [31:0] d, output int lat, output bit one);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    while (!bus.req_ready && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr = 24'($urandom);
    lat = 1;
    while (!bus.rdata_valid && lat < budget) begin
      @(negedge clock);
      lat++;
    end
    d = bus.rdata_valid ? bus.rdata : 'x;
    @(negedge clock);
    one = !bus.rdata_valid;
  endtask
  task automatic test_reset;
    tests += 6;
    if (flash_csb !== 1'b1) begin fails++; $display("FAIL reset_csb: got %b expected 1", flash_csb); end
    if (flash_clk !== 1'b0) begin fails++; $display("FAIL reset_clk: got %b expected 0", flash_clk); end
    if (flash_io0 !== 1'b0) begin fails++; $display("FAIL reset_io0: got %b expected 0", flash_io0); end
    if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    if (bus.rdata_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.rdata_valid); end
  endtask
  task automatic test_wake;
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    tests += 3;
    if (!bus.req_ready) begin fails++; $display("FAIL wake_ready: no req_ready after %0d cycles", n); end
    if (cmd_q.size() != 1 || cmd_q[0] !== 8'hAB)
      begin fails++; $display("FAIL wake_frame: got %0d frames first %h expected 1 frame AB", cmd_q.size(), cmd_q.size() ? cmd_q[0] : 8'h0); end
    if (flash_csb !== 1'b1) begin fails++; $display("FAIL wake_csb: got %b expected 1", flash_csb); end
  endtask
  task automatic test_read0;
    logic [31:0] d;
    int lat, n0;
    bit one;
    n0 = cmd_q.size();
    do_read(24'h000000, 200, d, lat, one);
    tests += 5;
    if (d !== 32'h44332211) begin fails++; $display("FAIL read0_data: got %h expected 44332211", d); end
    if (lat > 130) begin fails++; $display("FAIL read0_latency: got %0d expected <=130", lat); end
    if (!one) begin fails++; $display("FAIL read0_pulse: rdata_valid wider than 1 cycle"); end
    if (cmd_q.size() != n0 + 1 || cmd_q[$] !== 8'h03) begin fails++; $display("FAIL read0_cmd: got %0d new frames expected 1 with cmd 03", cmd_q.size() - n0); end
    if (addr_q.size() == 0 || addr_q[$] !== 24'h0) begin fails++; $display("FAIL read0_addr: got %h expected 000000", addr_q.size() ? addr_q[$] : 24'hx); end
  endtask
  task automatic test_seq;
    logic [31:0] d;
    int lat, n0;
    bit one;
    n0 = cmd_q.size();
    do_read(24'h000004, 100, d, lat, one);
    tests += 5;
    if (d !== 32'h88776655) begin fails++; $display("FAIL seq_data: got %h expected 88776655", d); end
    if (lat > 66) begin fails++; $display("FAIL seq_latency: got %0d expected <=66", lat); end
    if (!one) begin fails++; $display("FAIL seq_pulse: rdata_valid wider than 1 cycle"); end
    if (cmd_q.size() != n0) begin fails++; $display("FAIL seq_nocmd: got %0d new frames expected 0", cmd_q.size() - n0); end
    if (flash_csb !== 1'b0) begin fails++; $display("FAIL seq_csb: got %b expected 0", flash_csb); end
  endtask
  task automatic test_jump;
    logic [31:0] d;
    int lat, n0;
    bit one;
    n0 = cmd_q.size();
    do_read(24'h00000D, 250, d, lat, one);
    tests += 4;
    if (d !== 32'h00FFEEDD) begin fails++; $display("FAIL jump_data: got %h expected 00ffeedd", d); end
    if (last_hi < CSB_HIGH) begin fails++; $display("FAIL jump_csb_high: got %0d expected >=%0d", last_hi, CSB_HIGH); end
    if (cmd_q.size() != n0 + 1) begin fails++; $display("FAIL jump_cmd: got %0d new frames expected 1", cmd_q.size() - n0); end
    if (addr_q.size() == 0 || addr_q[$] !== 24'h00000C) begin fails++; $display("FAIL jump_addr: got %h expected 00000c", addr_q.size() ? addr_q[$] : 24'hx); end
  endtask
  task automatic test_wrap;
    logic [31:0] d;
    int lat, n0;
    bit one;
    do_read(24'hFFFFFC, 250, d, lat, one);
    tests += 4;
    if (d !== word_at(24'hFFFFFC)) begin fails++; $display("FAIL wrap_top_data: got %h expected %h", d, word_at(24'hFFFFFC)); end
    if (addr_q.size() == 0 || addr_q[$] !== 24'hFFFFFC) begin fails++; $display("FAIL wrap_top_addr: got %h expected fffffc", addr_q.size() ? addr_q[$] : 24'hx); end
    n0 = cmd_q.size();
    do_read(24'h000000, 100, d, lat, one);
    if (d !== 32'h44332211) begin fails++; $display("FAIL wrap_zero_data: got %h expected 44332211", d); end
    if (cmd_q.size() != n0 || lat > 66) begin fails++; $display("FAIL wrap_zero_seq: got %0d new frames latency %0d expected 0 and <=66", cmd_q.size() - n0, lat); end
  endtask
  task automatic test_random;
    logic [31:0] d;
    logic [23:0] a, prev, al;
    int lat, n0;
    bit one, seq;
    prev = 24'h000000;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 1) ? prev + 24'd4 + 24'($urandom_range(0, 3)) : 24'($urandom);
      al = {a[23:2], 2'b00};
      seq = al == prev + 24'd4;
      n0 = cmd_q.size();
      do_read(a, 300, d, lat, one);
      tests += 4;
      if (d !== word_at(a)) begin fails++; $display("FAIL rand_data[%0d]: addr %h got %h expected %h", i, a, d, word_at(a)); end
      if (cmd_q.size() != n0 + (seq ? 0 : 1)) begin fails++; $display("FAIL rand_frames[%0d]: addr %h got %0d new frames expected %0d", i, a, cmd_q.size() - n0, seq ? 0 : 1); end
      if (lat > (seq ? 66 : 130 + CSB_HIGH)) begin fails++; $display("FAIL rand_latency[%0d]: got %0d expected <=%0d", i, lat, seq ? 66 : 130 + CSB_HIGH); end
      if (!one) begin fails++; $display("FAIL rand_pulse[%0d]: rdata_valid wider than 1 cycle", i); end
      prev = al;
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] d;
    int lat, n = 0, p0, c0;
    bit one;
    bus.req_valid = 1'b1;
    bus.req_addr = 24'h000040;
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (40) @(negedge clock);
    p0 = pq.size();
    #5 reset = 1'b1;
    #1;
    tests += 2;
    if (flash_csb !== 1'b1) begin fails++; $display("FAIL mid_reset_csb: got %b expected 1", flash_csb); end
    if (flash_clk !== 1'b0) begin fails++; $display("FAIL mid_reset_clk: got %b expected 0", flash_clk); end
    repeat (5) @(negedge clock);
    c0 = cmd_q.size();
    reset = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    tests += 3;
    if (pq.size() != p0) begin fails++; $display("FAIL mid_reset_novalid: got %0d pulses expected 0", pq.size() - p0); end
    if (cmd_q.size() != c0 + 1 || cmd_q[$] !== 8'hAB) begin fails++; $display("FAIL mid_reset_wake: got %0d frames last %h expected 1 frame AB", cmd_q.size() - c0, cmd_q[$]); end
    do_read(24'h000000, 200, d, lat, one);
    if (d !== 32'h44332211) begin fails++; $display("FAIL mid_reset_read: got %h expected 44332211", d); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp3 [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    int n, p0, c0;
    p0 = pq.size();
    c0 = cmd_q.size();
    bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_addr = 24'(4 * k);
      n = 0;
      while (!bus.req_ready && n < 300) begin
        @(negedge clock);
        n++;
      end
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (pq.size() < p0 + 3 && n < 300) begin
      @(negedge clock);
      n++;
    end
    tests += 4;
    if (cmd_q.size() != c0 + 1) begin fails++; $display("FAIL b2b_frames: got %0d new frames expected 1", cmd_q.size() - c0); end
    for (int k = 0; k < 3; k++) begin
      if (pq.size() <= p0 + k) begin fails++; $display("FAIL b2b_word%0d: got no pulse expected %h", k, exp3[k]); end
      else if (pq[p0 + k] !== exp3[k]) begin fails++; $display("FAIL b2b_word%0d: got %h expected %h", k, pq[p0 + k], exp3[k]); end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i < 16 ? pre[i] : 8'($urandom);
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    reset = 1'b1;
    #500;
    test_reset;
    #500;
    reset = 1'b0;
    test_wake;
    test_read0;
    test_seq;
    test_jump;
    test_wrap;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
